// File: rtl/sensor_sim_pkg.sv
// Shared types and constants for the sensor simulation pattern generator.
// Optional PRBS support is selected with SENSOR_SIM_LFSR_EN.
package sensor_sim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HBLANK = 2'd1,
        ACTIVE = 2'd2,
        VBLANK = 2'd3
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    // Right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

`ifdef SENSOR_SIM_LFSR_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction
`endif

    // Bits needed to hold a counter running 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_sim_pgen_if.sv
// Pixel output bus (FV/LV/data) between a sensor source and its consumer.
interface sensor_sim_pgen_if #(
    parameter int LANES     = 1,
    parameter int PIX_WIDTH = 12
);
    logic                       frame_valid;
    logic                       line_valid;
    logic [LANES*PIX_WIDTH-1:0] dout;

    modport master (output frame_valid, line_valid, dout);
    modport slave  (input  frame_valid, line_valid, dout);
endinterface

// File: rtl/sensor_sim_pixel.sv
// One lane's pattern generator: combinational pattern select plus one output register.
// With SENSOR_SIM_LFSR_EN pattern 3 takes LFSR bits instead of the frame count.
module sensor_sim_pixel
    import sensor_sim_pkg::*;
#(
    parameter int PIX_WIDTH  = 12,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [31:0]           x,
    input  logic [31:0]           y,
    input  logic [1:0]            pattern,
`ifdef SENSOR_SIM_LFSR_EN
    input  logic [15:0]           lfsr,
`else
    input  logic [FCNT_WIDTH-1:0] frame_count,
`endif
    output logic [PIX_WIDTH-1:0]  pix
);

    logic [PIX_WIDTH-1:0]    pix_next;
    logic [PIX_WIDTH+31:0]   x_ext;
    logic [PIX_WIDTH+31:0]   y_ext;
`ifdef SENSOR_SIM_LFSR_EN
    logic [PIX_WIDTH+15:0]   flat_ext;
    assign flat_ext = {{PIX_WIDTH{1'b0}}, lfsr};
`else
    logic [PIX_WIDTH+FCNT_WIDTH-1:0] flat_ext;
    assign flat_ext = {{PIX_WIDTH{1'b0}}, frame_count};
`endif

    // Zero-extend before truncating so any PIX_WIDTH works for "mod 2^PIX_WIDTH".
    assign x_ext = {{PIX_WIDTH{1'b0}}, x};
    assign y_ext = {{PIX_WIDTH{1'b0}}, y};

    always_comb begin
        pix_next = '0;
        if (valid) begin
            case (pattern)
                PAT_HRAMP: pix_next = x_ext[PIX_WIDTH-1:0];
                PAT_VRAMP: pix_next = y_ext[PIX_WIDTH-1:0];
                PAT_CHECK: pix_next = {PIX_WIDTH{x[3] ^ y[3]}};
                default:   pix_next = flat_ext[PIX_WIDTH-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix <= '0;
        end else begin
            pix <= pix_next;
        end
    end

endmodule

// File: rtl/sensor_sim_pgen.sv
// Image-sensor stand-in: programmable FV/LV timing, multi-lane test patterns, free-run or triggered.
// Define SENSOR_SIM_LFSR_EN to replace the flat frame-count pattern with a per-frame PRBS.
module sensor_sim_pgen
    import sensor_sim_pkg::*;
#(
    parameter int PIX_WIDTH  = 12,
    parameter int LANES      = 1,
    parameter int H_ACTIVE   = 2592,
    parameter int H_BLANK    = 64,
    parameter int V_ACTIVE   = 1944,
    parameter int V_BLANK    = 1000,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  extclk,
    input  logic                  reset_b,
    input  logic                  enable,
    input  logic                  run_mode,
    input  logic                  trigger,
    input  logic [1:0]            pattern,
    sensor_sim_pgen_if.master     pix,
    output logic [FCNT_WIDTH-1:0] frame_count,
    output logic                  trig_overrun
);

    localparam int COLS = H_ACTIVE / LANES;
    localparam int CW   = cnt_width(COLS);
    localparam int RW   = cnt_width(V_ACTIVE);
    localparam int BW   = cnt_width((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);

    state_t                  state_reg, state_next;
    logic [BW-1:0]           cnt_reg, cnt_next;
    logic [CW-1:0]           col_reg, col_next;
    logic [RW-1:0]           row_reg, row_next;
    logic                    fv_reg, lv_reg;
    logic [1:0]              pattern_reg;
    logic                    run_mode_reg;
    logic [FCNT_WIDTH-1:0]   frame_count_reg;
    logic                    pending_reg, pending_next;
    logic                    overrun_reg, overrun_next;
    logic                    frame_start, frame_end;
    logic                    trig_acc;
    logic                    active_next;
    logic [LANES*PIX_WIDTH-1:0] dout_w;

    assign trig_acc    = trigger && run_mode;
    assign active_next = (state_next == ACTIVE);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        col_next    = col_reg;
        row_next    = row_reg;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && (!run_mode || pending_reg || trig_acc)) begin
                    state_next  = HBLANK;
                    frame_start = 1'b1;
                end
            end
            HBLANK: begin
                if (cnt_reg == BW'(H_BLANK - 1)) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                    col_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ACTIVE: begin
                if (col_reg == CW'(COLS - 1)) begin
                    col_next = '0;
                    cnt_next = '0;
                    if (row_reg == RW'(V_ACTIVE - 1)) begin
                        state_next = VBLANK;
                        frame_end  = 1'b1;
                    end else begin
                        row_next   = row_reg + 1'b1;
                        state_next = HBLANK;
                    end
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end
            VBLANK: begin
                if (cnt_reg == BW'(V_BLANK - 1)) begin
                    cnt_next = '0;
                    // Next-frame decision uses the run mode latched for the frame now ending.
                    if (enable && (!run_mode_reg || pending_reg)) begin
                        state_next  = HBLANK;
                        frame_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (frame_start) begin
            cnt_next = '0;
            col_next = '0;
            row_next = '0;
        end
    end

    // One-deep trigger queue; a start consumes it, extra requests only flag overrun.
    always_comb begin
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        if (trig_acc) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
        if (frame_start) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge extclk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            fv_reg          <= 1'b0;
            lv_reg          <= 1'b0;
            pattern_reg     <= PAT_HRAMP;
            run_mode_reg    <= 1'b0;
            frame_count_reg <= '0;
            pending_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            fv_reg       <= (state_next == HBLANK) || (state_next == ACTIVE);
            lv_reg       <= active_next;
            pending_reg  <= pending_next;
            overrun_reg  <= overrun_next;
            if (frame_start) begin
                pattern_reg  <= pattern;
                run_mode_reg <= run_mode;
            end
            if (frame_end) begin
                frame_count_reg <= frame_count_reg + 1'b1;
            end
        end
    end

`ifdef SENSOR_SIM_LFSR_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_chain [LANES+1];

    assign lfsr_chain[0] = lfsr_reg;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lfsr
        assign lfsr_chain[gi+1] = lfsr_step(lfsr_chain[gi]);
    end

    // Lane k of a beat uses the k-th successive state; the register skips ahead LANES steps.
    always_ff @(posedge extclk or negedge reset_b) begin
        if (!reset_b) begin
            lfsr_reg <= LFSR_SEED;
        end else if (frame_start) begin
            lfsr_reg <= LFSR_SEED;
        end else if (active_next) begin
            lfsr_reg <= lfsr_chain[LANES];
        end
    end
`endif

    // Pixels are computed from next-state coordinates so the registered data lines up with LV.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sensor_sim_pixel #(
            .PIX_WIDTH  (PIX_WIDTH),
            .FCNT_WIDTH (FCNT_WIDTH)
        ) u_pixel (
            .clk         (extclk),
            .rst_n       (reset_b),
            .valid       (active_next),
            .x           (32'(col_next) * 32'(LANES) + 32'(gi)),
            .y           (32'(row_next)),
            .pattern     (pattern_reg),
`ifdef SENSOR_SIM_LFSR_EN
            .lfsr        (lfsr_chain[gi]),
`else
            .frame_count (frame_count_reg),
`endif
            .pix         (dout_w[gi*PIX_WIDTH +: PIX_WIDTH])
        );
    end

    assign pix.frame_valid = fv_reg;
    assign pix.line_valid  = lv_reg;
    assign pix.dout        = dout_w;
    assign frame_count     = frame_count_reg;
    assign trig_overrun    = overrun_reg;

endmodule

// File: tb/tb_sensor_sim_pgen.sv
// Directed bench for sensor_sim_pgen: timing, patterns, trigger queue, enable drop and async reset.
module tb_sensor_sim_pgen;

`ifdef SENSOR_SIM_LFSR_EN
    localparam int PAT_FLAT_OR_V = 1;
`else
    localparam int PAT_FLAT_OR_V = 3;
`endif

    logic        extclk;
    logic        reset_b;
    logic        enable, run_mode, trigger;
    logic [1:0]  pattern;
    logic [15:0] frame_count;
    logic        trig_overrun;

    logic        enable_b;
    logic        run_mode_b, trigger_b;
    logic [1:0]  pattern_b;
    logic [15:0] frame_count_b;
    logic        trig_overrun_b;

    int checks = 0;
    int errors = 0;
    int cur_t  = 0;
    int lv_rises;
    logic lv_prev;

    sensor_sim_pgen_if #(.LANES(2), .PIX_WIDTH(12)) pix_a ();
    sensor_sim_pgen_if #(.LANES(2), .PIX_WIDTH(12)) pix_b ();

    sensor_sim_pgen #(
        .PIX_WIDTH(12), .LANES(2), .H_ACTIVE(8), .H_BLANK(4),
        .V_ACTIVE(4), .V_BLANK(6), .FCNT_WIDTH(16)
    ) dut_a (
        .extclk       (extclk),
        .reset_b      (reset_b),
        .enable       (enable),
        .run_mode     (run_mode),
        .trigger      (trigger),
        .pattern      (pattern),
        .pix          (pix_a),
        .frame_count  (frame_count),
        .trig_overrun (trig_overrun)
    );

    sensor_sim_pgen #(
        .PIX_WIDTH(12), .LANES(2), .H_ACTIVE(16), .H_BLANK(4),
        .V_ACTIVE(16), .V_BLANK(6), .FCNT_WIDTH(16)
    ) dut_b (
        .extclk       (extclk),
        .reset_b      (reset_b),
        .enable       (enable_b),
        .run_mode     (run_mode_b),
        .trigger      (trigger_b),
        .pattern      (pattern_b),
        .pix          (pix_b),
        .frame_count  (frame_count_b),
        .trig_overrun (trig_overrun_b)
    );

    initial extclk = 1'b0;
    always #5 extclk = ~extclk;

    task automatic step();
        @(posedge extclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp_v);
        end
    endtask

    // Expected DUT A outputs t cycles after a frame-start edge; frames are 38 clocks apart.
    task automatic chk_a(input int t, input int nframes, input int pat0, input int pat1, input int fc0);
        int f, p, row, c, pat, exp_fc;
        logic ev_fv, ev_lv;
        logic [11:0] l0, l1;
        cur_t  = t;
        f      = t / 38;
        p      = t % 38;
        exp_fc = fc0;
        for (int i = 0; i < nframes; i++) begin
            if (t >= i * 38 + 32) exp_fc++;
        end
        ev_fv = 1'b0;
        ev_lv = 1'b0;
        l0    = '0;
        l1    = '0;
        if (f < nframes && p < 32) begin
            ev_fv = 1'b1;
            row   = p / 8;
            if (p % 8 >= 4) begin
                ev_lv = 1'b1;
                c     = p % 8 - 4;
                pat   = (f == 0) ? pat0 : pat1;
                case (pat)
                    0:       begin l0 = 12'(2 * c); l1 = 12'(2 * c + 1); end
                    1:       begin l0 = 12'(row);   l1 = 12'(row);       end
                    default: begin l0 = 12'(fc0 + f); l1 = 12'(fc0 + f); end
                endcase
            end
        end
        chk("fv_a", 32'(pix_a.frame_valid), 32'(ev_fv));
        chk("lv_a", 32'(pix_a.line_valid), 32'(ev_lv));
        chk("dout_a", 32'(pix_a.dout), 32'({l1, l0}));
        chk("fcnt_a", 32'(frame_count), 32'(exp_fc));
    endtask

    // Checkerboard on the 16x16 instance: 12 clocks per line, 192 FV clocks, then VBLANK.
    task automatic chk_b(input int t);
        int row, c, x;
        logic ev_fv, ev_lv;
        logic [11:0] lane [2];
        cur_t   = t;
        ev_fv   = 1'b0;
        ev_lv   = 1'b0;
        lane[0] = '0;
        lane[1] = '0;
        if (t < 192) begin
            ev_fv = 1'b1;
            row   = t / 12;
            if (t % 12 >= 4) begin
                ev_lv = 1'b1;
                c     = t % 12 - 4;
                for (int k = 0; k < 2; k++) begin
                    x       = 2 * c + k;
                    lane[k] = (((x >> 3) ^ (row >> 3)) & 1) != 0 ? 12'hFFF : 12'h000;
                end
            end
        end
        chk("fv_b", 32'(pix_b.frame_valid), 32'(ev_fv));
        chk("lv_b", 32'(pix_b.line_valid), 32'(ev_lv));
        chk("dout_b", 32'(pix_b.dout), 32'({lane[1], lane[0]}));
    endtask

    initial begin
        reset_b    = 1'b0;
        enable     = 1'b0;
        run_mode   = 1'b0;
        trigger    = 1'b0;
        pattern    = 2'd0;
        enable_b   = 1'b0;
        run_mode_b = 1'b0;
        trigger_b  = 1'b0;
        pattern_b  = 2'd2;

        // Reset state
        step();
        step();
        chk("rst_fv", 32'(pix_a.frame_valid), 32'd0);
        chk("rst_lv", 32'(pix_a.line_valid), 32'd0);
        chk("rst_dout", 32'(pix_a.dout), 32'd0);
        chk("rst_fcnt", 32'(frame_count), 32'd0);
        chk("rst_ovr", 32'(trig_overrun), 32'd0);

        // Free-run, horizontal ramp, two frames
        reset_b = 1'b1;
        enable  = 1'b1;
        step();
        for (int t = 0; t < 76; t++) begin
            chk_a(t, 2, 0, 0, 0);
            step();
        end
        repeat (4) step();
        chk_a(80, 3, 0, 0, 0);

        // Asynchronous reset in the middle of ACTIVE, no clock edge before sampling
        reset_b = 1'b0;
        #1;
        cur_t = 81;
        chk("arst_fv", 32'(pix_a.frame_valid), 32'd0);
        chk("arst_lv", 32'(pix_a.line_valid), 32'd0);
        chk("arst_dout", 32'(pix_a.dout), 32'd0);
        chk("arst_fcnt", 32'(frame_count), 32'd0);
        #2;
        reset_b = 1'b1;

        // Restart from row 0, then drop enable during row 1: frame finishes, then idle
        step();
        lv_rises = 0;
        lv_prev  = 1'b0;
        for (int t = 0; t < 46; t++) begin
            chk_a(t, 1, 0, 0, 0);
            if (pix_a.line_valid && !lv_prev) lv_rises++;
            lv_prev = pix_a.line_valid;
            if (t == 10) enable = 1'b0;
            step();
        end
        chk("lv_pulses", 32'(lv_rises), 32'd4);

        // Triggered mode: idle without a trigger, then exactly one frame per trigger
        reset_b  = 1'b0;
        enable   = 1'b1;
        run_mode = 1'b1;
        pattern  = 2'd1;
        step();
        step();
        reset_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            cur_t = t;
            chk("trg_idle_fv", 32'(pix_a.frame_valid), 32'd0);
        end
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int t = 0; t < 48; t++) begin
            chk_a(t, 1, 1, 1, 0);
            step();
        end

        // Three triggers: one starts a frame, one queues, one overruns; pattern shadowed per frame
        trigger = 1'b1;
        pattern = 2'(PAT_FLAT_OR_V);
        step();
        trigger = 1'b0;
        for (int t = 0; t < 86; t++) begin
            chk_a(t, 2, PAT_FLAT_OR_V, 0, 1);
            if (t == 5 || t == 12) trigger = 1'b1;
            if (t == 6 || t == 13) trigger = 1'b0;
            if (t == 6)  chk("ovr_after_2nd", 32'(trig_overrun), 32'd0);
            if (t == 13) chk("ovr_after_3rd", 32'(trig_overrun), 32'd1);
            if (t == 20) pattern = 2'd0;
            step();
        end
        cur_t = 86;
        chk("ovr_sticky", 32'(trig_overrun), 32'd1);

        // Checkerboard on the 16x16 instance
        enable   = 1'b0;
        enable_b = 1'b1;
        step();
        for (int t = 0; t < 198; t++) begin
            chk_b(t);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
